// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared state encoding and branch-op constants for fetch control
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT,
    S_FAULT
  } state_t;

  localparam logic [2:0] BR_SEQ    = 3'b000;
  localparam logic [2:0] BR_COND   = 3'b001;
  localparam logic [2:0] BR_UNCOND = 3'b010;
  localparam logic [2:0] BR_TARGET = 3'b011;

  // Reserved encodings (1xx) degrade to sequential flow.
  function automatic logic [2:0] br_issue(input logic [2:0] op);
    return op[2] ? BR_SEQ : op;
  endfunction

endpackage

// File: rtl/fetch_wdog.sv
// rtl/fetch_wdog.sv - fetch wait counter, expires after WAIT_MAX-1 unacknowledged cycles
module fetch_wdog #(
  parameter int WAIT_MAX = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expire
);

  localparam int W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_count && !o_expire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = (r_cnt == W'(WAIT_MAX - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch/decode/execute sequencer with fetch timeout
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             imem_ack,
  input  logic [2:0]       br_op,
  input  logic             cond,
  input  logic             halt_op,
  output logic             imem_req,
  output logic             ir_load,
  output logic             pc_en,
  output logic [2:0]       branch,
  output logic             jcnd,
  output logic             done,
  output logic             fault,
  output logic [CNT_W-1:0] insn_cnt
);

  state_t           r_state;
  logic [2:0]       r_br_op;
  logic             r_cond;
  logic [CNT_W-1:0] r_insn_cnt;

  logic w_clear;
  logic w_count;
  logic w_expire;

  // Counter sits at zero outside FETCH, so every FETCH entry starts fresh.
  assign w_clear = (r_state != S_FETCH);
  assign w_count = (r_state == S_FETCH) && !imem_ack;

  fetch_wdog #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_clear),
    .i_count (w_count),
    .o_expire(w_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_br_op    <= BR_SEQ;
      r_cond     <= 1'b0;
      r_insn_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_FETCH;
            r_insn_cnt <= '0;
          end
        end
        S_FETCH: begin
          // An ack arriving on the expiry cycle still wins over the timeout.
          if (imem_ack) begin
            r_state <= S_DECODE;
          end else if (w_expire) begin
            r_state <= S_FAULT;
          end
        end
        S_DECODE: begin
          r_br_op <= br_op;
          r_cond  <= cond;
          r_state <= halt_op ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          if (r_insn_cnt != '1) begin
            r_insn_cnt <= r_insn_cnt + 1'b1;
          end
          r_state <= S_FETCH;
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  assign imem_req = (r_state == S_FETCH);
  assign ir_load  = (r_state == S_FETCH) && imem_ack;
  assign pc_en    = (r_state == S_EXEC);
  assign branch   = (r_state == S_EXEC) ? br_issue(r_br_op) : BR_SEQ;
  assign jcnd     = (r_state == S_EXEC) && (r_br_op == BR_COND) && r_cond;
  assign done     = (r_state == S_HALT);
  assign fault    = (r_state == S_FAULT);
  assign insn_cnt = r_insn_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        imem_ack = 1'b0;
  logic [2:0]  br_op = 3'b000;
  logic        cond = 1'b0;
  logic        halt_op = 1'b0;

  logic        imem_req, ir_load, pc_en, jcnd, done, fault;
  logic [2:0]  branch;
  logic [15:0] insn_cnt;

  logic        s_imem_req, s_ir_load, s_pc_en, s_jcnd, s_done, s_fault;
  logic [2:0]  s_branch;
  logic [3:0]  s_insn_cnt;

  int total = 0;
  int bad = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_ctrl #(.CNT_W(16), .WAIT_MAX(8)) dut (
    .clk(clk), .reset(reset), .start(start), .imem_ack(imem_ack),
    .br_op(br_op), .cond(cond), .halt_op(halt_op),
    .imem_req(imem_req), .ir_load(ir_load), .pc_en(pc_en), .branch(branch),
    .jcnd(jcnd), .done(done), .fault(fault), .insn_cnt(insn_cnt)
  );

  fetch_ctrl #(.CNT_W(4), .WAIT_MAX(8)) dut_s (
    .clk(clk), .reset(reset), .start(start), .imem_ack(imem_ack),
    .br_op(br_op), .cond(cond), .halt_op(halt_op),
    .imem_req(s_imem_req), .ir_load(s_ir_load), .pc_en(s_pc_en), .branch(s_branch),
    .jcnd(s_jcnd), .done(s_done), .fault(s_fault), .insn_cnt(s_insn_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; imem_ack = 1'b0;
    br_op = 3'b000; cond = 1'b0; halt_op = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_pc(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (pc_en === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    total++;
    if ({imem_req, ir_load, pc_en, branch, jcnd, done, fault} !== 9'b0 || insn_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b cnt=%0d want=0", {imem_req, ir_load, pc_en, branch, jcnd, done, fault}, insn_cnt);
    end
    total++;
    if ({s_imem_req, s_ir_load, s_pc_en, s_branch, s_jcnd, s_done, s_fault, s_insn_cnt} !== 13'b0) begin
      bad++;
      $display("FAIL reset_outputs_small got=%b want=0", {s_imem_req, s_ir_load, s_pc_en, s_branch, s_jcnd, s_done, s_fault, s_insn_cnt});
    end
    tick(); tick();
    reset = 1'b1;
    imem_ack = 1'b1;
    repeat (3) tick();
    total++;
    if (imem_req !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_start got imem_req=%b want=0", imem_req);
    end
  endtask

  task automatic test_seq();
    do_reset();
    imem_ack = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      total++;
      if (pc_en !== ((c % 3) == 0)) begin
        bad++;
        $display("FAIL seq_pc_en cycle=%0d got=%b want=%b", c, pc_en, ((c % 3) == 0));
      end
      tick();
    end
    total++;
    if (insn_cnt !== 16'd3) begin
      bad++;
      $display("FAIL seq_insn_cnt got=%0d want=3", insn_cnt);
    end
  endtask

  task automatic test_branch_types();
    logic [2:0] brs[6];
    logic       cs[6];
    logic [3:0] want;
    logic [2:0] wb;
    bit ok;
    brs = '{3'b001, 3'b001, 3'b011, 3'b010, 3'b101, 3'b100};
    cs  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    imem_ack = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      br_op = brs[i];
      cond  = cs[i];
      wb = brs[i];
      if (wb[2]) wb = 3'b000;
      exp_q.push_back({wb, (brs[i] == 3'b001) && cs[i]});
      total++;
      if (pc_en !== 1'b0 || branch !== 3'b000 || jcnd !== 1'b0) begin
        bad++;
        $display("FAIL outside_exec got pc_en=%b branch=%b jcnd=%b want 0/000/0", pc_en, branch, jcnd);
      end
      wait_pc(ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL branch_exec_timeout insn=%0d got no pc_en want pc_en=1", i);
        void'(exp_q.pop_front());
      end else begin
        want = exp_q.pop_front();
        if ({branch, jcnd} !== want) begin
          bad++;
          $display("FAIL branch_exec insn=%0d got branch=%b jcnd=%b want branch=%b jcnd=%b", i, branch, jcnd, want[3:1], want[0]);
        end
      end
      tick();
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_timeout();
    do_reset();
    imem_ack = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      total++;
      if (imem_req !== 1'b1 || fault !== 1'b0) begin
        bad++;
        $display("FAIL timeout_wait cycle=%0d got req=%b fault=%b want req=1 fault=0", c, imem_req, fault);
      end
      tick();
    end
    total++;
    if (fault !== 1'b1 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL timeout_fault got fault=%b req=%b want fault=1 req=0", fault, imem_req);
    end
    start = 1'b1;
    imem_ack = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    total++;
    if (fault !== 1'b1 || imem_req !== 1'b0 || pc_en !== 1'b0) begin
      bad++;
      $display("FAIL fault_sticky got fault=%b req=%b pc_en=%b want 1/0/0", fault, imem_req, pc_en);
    end
  endtask

  task automatic test_ack_last();
    do_reset();
    imem_ack = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    imem_ack = 1'b1;
    #1;
    total++;
    if (ir_load !== 1'b1 || imem_req !== 1'b1) begin
      bad++;
      $display("FAIL ack_last_load got ir_load=%b req=%b want 1/1", ir_load, imem_req);
    end
    tick();
    total++;
    if (fault !== 1'b0 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL ack_last_decode got fault=%b req=%b want 0/0", fault, imem_req);
    end
    tick();
    total++;
    if (pc_en !== 1'b1) begin
      bad++;
      $display("FAIL ack_last_exec got pc_en=%b want 1", pc_en);
    end
  endtask

  task automatic test_halt();
    int pulses;
    do_reset();
    imem_ack = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 4) halt_op = 1'b1;
      if (pc_en === 1'b1) pulses++;
      if (c < 6) tick();
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL halt_done got=%b want=1", done);
    end
    total++;
    if (pulses != 1 || insn_cnt !== 16'd1) begin
      bad++;
      $display("FAIL halt_count got pulses=%0d cnt=%0d want pulses=1 cnt=1", pulses, insn_cnt);
    end
    halt_op = 1'b0;
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    total++;
    if (done !== 1'b1 || imem_req !== 1'b0 || pc_en !== 1'b0 || insn_cnt !== 16'd1) begin
      bad++;
      $display("FAIL halt_sticky got done=%b req=%b pc_en=%b cnt=%0d want 1/0/0/1", done, imem_req, pc_en, insn_cnt);
    end
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    imem_ack = 1'b1;
    br_op = 3'b011;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    total++;
    if (pc_en !== 1'b1 || branch !== 3'b011 || insn_cnt !== 16'd1) begin
      bad++;
      $display("FAIL pre_reset_exec got pc_en=%b branch=%b cnt=%0d want 1/011/1", pc_en, branch, insn_cnt);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({imem_req, ir_load, pc_en, branch, jcnd, done, fault} !== 9'b0 || insn_cnt !== 16'd0) begin
      bad++;
      $display("FAIL mid_exec_reset got=%b cnt=%0d want=0", {imem_req, ir_load, pc_en, branch, jcnd, done, fault}, insn_cnt);
    end
    tick(); tick();
    reset = 1'b1;
    repeat (3) tick();
    total++;
    if (imem_req !== 1'b0 || pc_en !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle got req=%b pc_en=%b want 0/0", imem_req, pc_en);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (imem_req !== 1'b1) begin
      bad++;
      $display("FAIL resume_fetch got req=%b want 1", imem_req);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    imem_ack = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (60) tick();
    total++;
    if (s_insn_cnt !== 4'd15) begin
      bad++;
      $display("FAIL saturate_small got=%0d want=15", s_insn_cnt);
    end
    total++;
    if (insn_cnt !== 16'd20) begin
      bad++;
      $display("FAIL count_wide got=%0d want=20", insn_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_branch_types();
    test_timeout();
    test_ack_last();
    test_halt();
    test_reset_mid_exec();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
